// File: rtl/siganfu_machine_gun_mk2.sv
// Turret fire controller: IDLE/ENGAGE/FIRING/RELOAD/OVERHEAT/DOWNFALL with single/burst/auto modes.
// Latency: all outputs registered; first fire_trigger one edge after FIRING is entered.
// Backpressure: none; overheat_sensor preempts firing. Optional shot counter under SMG_SHOT_COUNT_EN.
module siganfu_machine_gun_mk2 #(
    parameter int MAG_SIZE        = 25,
    parameter int MAG_COUNT       = 2,
    parameter int BURST_LEN       = 3,
    parameter int RELOAD_CYCLES   = 5,
    parameter int COOLDOWN_CYCLES = 10,
    parameter int CNT_W           = 5,
    parameter int MAG_W           = 2
) (
    input  logic             sysclk,
    input  logic             reboot,
    input  logic             is_enemy,
    input  logic             target_locked,
    input  logic             fire_command,
    input  logic [1:0]       firing_mode,
    input  logic             overheat_sensor,
    output logic [2:0]       current_state,
    output logic             criticality_alert,
    output logic             fire_trigger,
    output logic [CNT_W-1:0] rounds_left,
    output logic [MAG_W-1:0] mags_left
`ifdef SMG_SHOT_COUNT_EN
    ,
    output logic [15:0]      total_shots
`endif
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int RW = $clog2(RELOAD_CYCLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENGAGE   = 3'd1,
        S_FIRING   = 3'd2,
        S_RELOAD   = 3'd3,
        S_OVERHEAT = 3'd4,
        S_DOWNFALL = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rounds_q, rounds_d;
    logic [MAG_W-1:0] mags_q, mags_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [RW-1:0]    rld_q, rld_d;
    logic [CW-1:0]    cool_q, cool_d;
    logic             cmd_q;
    logic             trig_q;
    logic             alert_q;
    logic             shot;
    logic             valid;
    logic             rise;
    logic             auto_m;
    logic             burst_m;

    assign valid   = is_enemy & target_locked;
    assign rise    = fire_command & ~cmd_q;
    assign auto_m  = (firing_mode == 2'b10);
    assign burst_m = (firing_mode == 2'b01);

    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        mags_d   = mags_q;
        burst_d  = burst_q;
        rld_d    = rld_q;
        cool_d   = cool_q;
        shot     = 1'b0;
        if (overheat_sensor && state_q != S_DOWNFALL) begin
            // Sensor high both enters OVERHEAT and keeps re-arming the full cooldown.
            state_d = S_OVERHEAT;
            cool_d  = CW'(COOLDOWN_CYCLES);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid) state_d = S_ENGAGE;
                end
                S_ENGAGE: begin
                    if (!valid) begin
                        state_d = S_IDLE;
                    end else if (auto_m ? fire_command : rise) begin
                        state_d = S_FIRING;
                        burst_d = burst_m ? BW'(BURST_LEN) : BW'(1);
                    end
                end
                S_FIRING: begin
                    if (!valid) begin
                        state_d = S_IDLE;
                    end else if (auto_m && !fire_command) begin
                        state_d = S_ENGAGE;
                    end else begin
                        if (rounds_q != '0) begin
                            shot     = 1'b1;
                            rounds_d = rounds_q - CNT_W'(1);
                        end
                        if (burst_q != '0) burst_d = burst_q - BW'(1);
                        // Emptying the magazine overrides whatever is left of the burst.
                        if (rounds_q <= CNT_W'(1)) begin
                            state_d = (mags_q != '0) ? S_RELOAD : S_DOWNFALL;
                            rld_d   = RW'(RELOAD_CYCLES);
                        end else if (!auto_m && burst_q <= BW'(1)) begin
                            state_d = S_ENGAGE;
                        end
                    end
                end
                S_RELOAD: begin
                    if (rld_q <= RW'(1)) begin
                        rld_d    = '0;
                        rounds_d = CNT_W'(MAG_SIZE);
                        if (mags_q != '0) mags_d = mags_q - MAG_W'(1);
                        state_d  = valid ? S_ENGAGE : S_IDLE;
                    end else begin
                        rld_d = rld_q - RW'(1);
                    end
                end
                S_OVERHEAT: begin
                    if (cool_q <= CW'(1)) begin
                        cool_d = '0;
                        if (rounds_q == '0 && mags_q != '0) begin
                            state_d = S_RELOAD;
                            rld_d   = RW'(RELOAD_CYCLES);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cool_d = cool_q - CW'(1);
                    end
                end
                S_DOWNFALL: begin
                    state_d = S_DOWNFALL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reboot) begin
            state_q  <= S_IDLE;
            rounds_q <= CNT_W'(MAG_SIZE);
            mags_q   <= MAG_W'(MAG_COUNT);
            burst_q  <= '0;
            rld_q    <= '0;
            cool_q   <= '0;
            cmd_q    <= 1'b0;
            trig_q   <= 1'b0;
            alert_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
            mags_q   <= mags_d;
            burst_q  <= burst_d;
            rld_q    <= rld_d;
            cool_q   <= cool_d;
            cmd_q    <= fire_command;
            trig_q   <= shot;
            alert_q  <= (state_d == S_OVERHEAT) || (state_d == S_DOWNFALL);
        end
    end

    assign current_state     = state_q;
    assign criticality_alert = alert_q;
    assign fire_trigger      = trig_q;
    assign rounds_left       = rounds_q;
    assign mags_left         = mags_q;

`ifdef SMG_SHOT_COUNT_EN
    logic [15:0] shots_q;

    always_ff @(posedge sysclk) begin
        if (reboot) begin
            shots_q <= '0;
        end else if (shot && shots_q != 16'hFFFF) begin
            shots_q <= shots_q + 16'd1;
        end
    end

    assign total_shots = shots_q;
`endif

endmodule

// File: tb/tb_siganfu_machine_gun_mk2.sv
// Scenario bench for siganfu_machine_gun_mk2: queued expected rounds_left per pulse plus state/timing checks.
module tb_siganfu_machine_gun_mk2;

    logic       sysclk = 1'b0;
    logic       reboot;
    logic       is_enemy;
    logic       target_locked;
    logic       fire_command;
    logic [1:0] firing_mode;
    logic       overheat_sensor;
    logic [2:0] current_state;
    logic       criticality_alert;
    logic       fire_trigger;
    logic [4:0] rounds_left;
    logic [1:0] mags_left;
`ifdef SMG_SHOT_COUNT_EN
    logic [15:0] total_shots;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int exp_q[$];

    siganfu_machine_gun_mk2 dut (
        .sysclk           (sysclk),
        .reboot           (reboot),
        .is_enemy         (is_enemy),
        .target_locked    (target_locked),
        .fire_command     (fire_command),
        .firing_mode      (firing_mode),
        .overheat_sensor  (overheat_sensor),
        .current_state    (current_state),
        .criticality_alert(criticality_alert),
        .fire_trigger     (fire_trigger),
        .rounds_left      (rounds_left),
        .mags_left        (mags_left)
`ifdef SMG_SHOT_COUNT_EN
        ,
        .total_shots      (total_shots)
`endif
    );

    always #5 sysclk = ~sysclk;

    // Advance one edge; every pulse pops the rounds_left value the scenario predicted for it.
    task automatic cycle();
        int e;
        @(posedge sysclk);
        #1;
        if (fire_trigger === 1'b1) begin
            pulses++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: pulse seen with rounds_left=%0d, required no pulse", rounds_left);
            end else begin
                e = exp_q.pop_front();
                if (rounds_left !== 5'(e)) begin
                    miscompares++;
                    $display("FAIL pulse_rounds: rounds_left=%0d, required %0d", rounds_left, e);
                end
            end
        end
    endtask

    task automatic do_reboot();
        reboot          = 1'b1;
        is_enemy        = 1'b0;
        target_locked   = 1'b0;
        fire_command    = 1'b0;
        firing_mode     = 2'b00;
        overheat_sensor = 1'b0;
        cycle();
        reboot = 1'b0;
        exp_q.delete();
        pulses = 0;
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_pulses: %0d expected pulses never seen, required 0", name, exp_q.size());
        end
`ifdef SMG_SHOT_COUNT_EN
        vectors++;
        if (total_shots !== 16'(pulses)) begin
            miscompares++;
            $display("FAIL %s_total_shots: got %0d, required %0d", name, total_shots, pulses);
        end
`endif
    endtask

    task automatic test_reset();
        reboot          = 1'b1;
        is_enemy        = 1'b1;
        target_locked   = 1'b1;
        fire_command    = 1'b1;
        firing_mode     = 2'b10;
        overheat_sensor = 1'b1;
        cycle();
        cycle();
        vectors += 5;
        if (current_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d, required 0", current_state); end
        if (rounds_left !== 5'd25) begin miscompares++; $display("FAIL reset_rounds: got %0d, required 25", rounds_left); end
        if (mags_left !== 2'd2) begin miscompares++; $display("FAIL reset_mags: got %0d, required 2", mags_left); end
        if (fire_trigger !== 1'b0) begin miscompares++; $display("FAIL reset_trigger: got %0b, required 0", fire_trigger); end
        if (criticality_alert !== 1'b0) begin miscompares++; $display("FAIL reset_alert: got %0b, required 0", criticality_alert); end
`ifdef SMG_SHOT_COUNT_EN
        vectors++;
        if (total_shots !== 16'd0) begin miscompares++; $display("FAIL reset_total_shots: got %0d, required 0", total_shots); end
`endif
        reboot = 1'b0;
    endtask

    task automatic test_auto_full();
        do_reboot();
        is_enemy = 1'b1; target_locked = 1'b1; firing_mode = 2'b10; fire_command = 1'b1;
        for (int m = 0; m < 3; m++)
            for (int r = 24; r >= 0; r--) exp_q.push_back(r);
        repeat (27) cycle();
        vectors += 4;
        if (pulses != 25) begin miscompares++; $display("FAIL auto_mag1_pulses: got %0d, required 25", pulses); end
        if (current_state !== 3'd3) begin miscompares++; $display("FAIL auto_enter_reload: got %0d, required 3", current_state); end
        if (rounds_left !== 5'd0) begin miscompares++; $display("FAIL auto_empty_rounds: got %0d, required 0", rounds_left); end
        if (mags_left !== 2'd2) begin miscompares++; $display("FAIL auto_mags_before_reload: got %0d, required 2", mags_left); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (current_state !== 3'd3) begin miscompares++; $display("FAIL auto_reload_hold: cycle %0d state %0d, required 3", i, current_state); end
        end
        cycle();
        vectors += 3;
        if (current_state !== 3'd1) begin miscompares++; $display("FAIL auto_reload_exit: got %0d, required 1", current_state); end
        if (rounds_left !== 5'd25) begin miscompares++; $display("FAIL auto_reload_rounds: got %0d, required 25", rounds_left); end
        if (mags_left !== 2'd1) begin miscompares++; $display("FAIL auto_reload_mags: got %0d, required 1", mags_left); end
        cycle();
        vectors++;
        if (current_state !== 3'd2 || pulses != 25) begin
            miscompares++;
            $display("FAIL auto_reengage: state %0d pulses %0d, required 2 and 25", current_state, pulses);
        end
        cycle();
        vectors++;
        if (pulses != 26) begin miscompares++; $display("FAIL auto_resume: pulses %0d, required 26", pulses); end
        for (int i = 0; i < 200 && current_state !== 3'd5; i++) cycle();
        vectors += 3;
        if (current_state !== 3'd5) begin miscompares++; $display("FAIL auto_downfall: got %0d, required 5", current_state); end
        if (criticality_alert !== 1'b1) begin miscompares++; $display("FAIL auto_downfall_alert: got %0b, required 1", criticality_alert); end
        if (pulses != 75) begin miscompares++; $display("FAIL auto_total_pulses: got %0d, required 75", pulses); end
        for (int i = 0; i < 100; i++) begin
            overheat_sensor = i[0];
            fire_command    = 1'($urandom);
            is_enemy        = 1'($urandom);
            cycle();
            vectors++;
            if (current_state !== 3'd5 || criticality_alert !== 1'b1) begin
                miscompares++;
                $display("FAIL downfall_hold: cycle %0d state %0d alert %0b, required 5 and 1", i, current_state, criticality_alert);
            end
        end
        check_drained("auto");
        overheat_sensor = 1'b0;
        reboot = 1'b1;
        cycle();
        reboot = 1'b0;
        vectors += 4;
        if (current_state !== 3'd0) begin miscompares++; $display("FAIL reboot_state: got %0d, required 0", current_state); end
        if (rounds_left !== 5'd25) begin miscompares++; $display("FAIL reboot_rounds: got %0d, required 25", rounds_left); end
        if (mags_left !== 2'd2) begin miscompares++; $display("FAIL reboot_mags: got %0d, required 2", mags_left); end
        if (criticality_alert !== 1'b0) begin miscompares++; $display("FAIL reboot_alert: got %0b, required 0", criticality_alert); end
    endtask

    task automatic test_burst();
        do_reboot();
        is_enemy = 1'b1; target_locked = 1'b1; firing_mode = 2'b01;
        cycle();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(24 - 3 * b - k);
            fire_command = 1'b1;
            cycle();
            fire_command = 1'b0;
            repeat (9) cycle();
        end
        vectors += 3;
        if (pulses != 9) begin miscompares++; $display("FAIL burst_pulses: got %0d, required 9", pulses); end
        if (rounds_left !== 5'd16) begin miscompares++; $display("FAIL burst_rounds: got %0d, required 16", rounds_left); end
        if (current_state !== 3'd1) begin miscompares++; $display("FAIL burst_state: got %0d, required 1", current_state); end
        for (int k = 15; k >= 13; k--) exp_q.push_back(k);
        fire_command = 1'b1;
        repeat (15) cycle();
        vectors += 2;
        if (pulses != 12) begin miscompares++; $display("FAIL burst_hold_pulses: got %0d, required 12", pulses); end
        if (rounds_left !== 5'd13) begin miscompares++; $display("FAIL burst_hold_rounds: got %0d, required 13", rounds_left); end
        check_drained("burst");
    endtask

    task automatic test_single();
        do_reboot();
        is_enemy = 1'b1; target_locked = 1'b1; firing_mode = 2'b00;
        cycle();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(24 - k);
            fire_command = 1'b1;
            cycle();
            fire_command = 1'b0;
            repeat (3) cycle();
        end
        vectors += 2;
        if (pulses != 4) begin miscompares++; $display("FAIL single_pulses: got %0d, required 4", pulses); end
        if (rounds_left !== 5'd21) begin miscompares++; $display("FAIL single_rounds: got %0d, required 21", rounds_left); end
        firing_mode = 2'b11;
        exp_q.push_back(20);
        fire_command = 1'b1;
        cycle();
        fire_command = 1'b0;
        repeat (3) cycle();
        vectors += 2;
        if (pulses != 5) begin miscompares++; $display("FAIL mode3_pulses: got %0d, required 5", pulses); end
        if (current_state !== 3'd1) begin miscompares++; $display("FAIL mode3_state: got %0d, required 1", current_state); end
        firing_mode = 2'b01;
        exp_q.push_back(19);
        fire_command = 1'b1;
        cycle();
        fire_command = 1'b0;
        cycle();
        is_enemy = 1'b0;
        cycle();
        vectors += 2;
        if (current_state !== 3'd0) begin miscompares++; $display("FAIL abort_state: got %0d, required 0", current_state); end
        if (rounds_left !== 5'd19) begin miscompares++; $display("FAIL abort_rounds: got %0d, required 19", rounds_left); end
        repeat (3) cycle();
        vectors++;
        if (pulses != 6) begin miscompares++; $display("FAIL abort_pulses: got %0d, required 6", pulses); end
        check_drained("single");
    endtask

    task automatic test_overheat();
        do_reboot();
        is_enemy = 1'b1; target_locked = 1'b1; firing_mode = 2'b10; fire_command = 1'b1;
        for (int k = 24; k >= 20; k--) exp_q.push_back(k);
        repeat (7) cycle();
        overheat_sensor = 1'b1;
        cycle();
        vectors += 4;
        if (current_state !== 3'd4) begin miscompares++; $display("FAIL oh_state: got %0d, required 4", current_state); end
        if (criticality_alert !== 1'b1) begin miscompares++; $display("FAIL oh_alert: got %0b, required 1", criticality_alert); end
        if (rounds_left !== 5'd20) begin miscompares++; $display("FAIL oh_rounds: got %0d, required 20", rounds_left); end
        if (pulses != 5) begin miscompares++; $display("FAIL oh_pulses: got %0d, required 5", pulses); end
        repeat (2) cycle();
        overheat_sensor = 1'b0;
        fire_command    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            vectors++;
            if (current_state !== 3'd4) begin miscompares++; $display("FAIL oh_cooling: low cycle %0d state %0d, required 4", i + 1, current_state); end
        end
        cycle();
        vectors += 2;
        if (current_state !== 3'd0) begin miscompares++; $display("FAIL oh_exit: got %0d, required 0", current_state); end
        if (criticality_alert !== 1'b0) begin miscompares++; $display("FAIL oh_exit_alert: got %0b, required 0", criticality_alert); end
        overheat_sensor = 1'b1;
        cycle();
        overheat_sensor = 1'b0;
        repeat (6) cycle();
        overheat_sensor = 1'b1;
        cycle();
        overheat_sensor = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            vectors++;
            if (current_state !== 3'd4) begin miscompares++; $display("FAIL oh_restart: low cycle %0d state %0d, required 4", i + 1, current_state); end
        end
        cycle();
        vectors++;
        if (current_state !== 3'd0) begin miscompares++; $display("FAIL oh_restart_exit: got %0d, required 0", current_state); end
        check_drained("overheat");
    endtask

    task automatic test_reload_abort();
        do_reboot();
        is_enemy = 1'b1; target_locked = 1'b1; firing_mode = 2'b10; fire_command = 1'b1;
        for (int k = 24; k >= 0; k--) exp_q.push_back(k);
        repeat (27) cycle();
        repeat (2) cycle();
        overheat_sensor = 1'b1;
        fire_command    = 1'b0;
        cycle();
        vectors += 3;
        if (current_state !== 3'd4) begin miscompares++; $display("FAIL abort_reload_state: got %0d, required 4", current_state); end
        if (rounds_left !== 5'd0) begin miscompares++; $display("FAIL abort_reload_rounds: got %0d, required 0", rounds_left); end
        if (mags_left !== 2'd2) begin miscompares++; $display("FAIL abort_reload_mags: got %0d, required 2", mags_left); end
        overheat_sensor = 1'b0;
        repeat (10) cycle();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (current_state !== 3'd3) begin miscompares++; $display("FAIL rereload_hold: cycle %0d state %0d, required 3", i, current_state); end
            cycle();
        end
        vectors += 3;
        if (current_state !== 3'd1) begin miscompares++; $display("FAIL rereload_exit: got %0d, required 1", current_state); end
        if (rounds_left !== 5'd25) begin miscompares++; $display("FAIL rereload_rounds: got %0d, required 25", rounds_left); end
        if (mags_left !== 2'd1) begin miscompares++; $display("FAIL rereload_mags: got %0d, required 1", mags_left); end
        check_drained("reload_abort");
    endtask

    initial begin
        test_reset();
        test_auto_full();
        test_burst();
        test_single();
        test_overheat();
        test_reload_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/siganfu_machine_gun_mk2.md
Name: siganfu_machine_gun_mk2

Overview:
Parametrised second-generation turret fire controller. Adds configurable magazine size, spare-magazine count, reload and cooldown durations, and a 2-bit firing mode (single/burst/auto). Exposes round and magazine counters to the fire-control bus. Sits between the targeting/IFF logic and the trigger solenoid driver.

Parameters:
MAG_SIZE, 25, rounds per magazine (>=1)
MAG_COUNT, 2, spare magazines at reboot (total magazines = MAG_COUNT+1)
BURST_LEN, 3, rounds per burst (1..MAG_SIZE)
RELOAD_CYCLES, 5, sysclk cycles spent in RELOAD (>=1)
COOLDOWN_CYCLES, 10, consecutive sensor-low cycles required to leave OVERHEAT (>=1)
CNT_W, 5, rounds_left width; must hold MAG_SIZE
MAG_W, 2, mags_left width; must hold MAG_COUNT

Ports:
sysclk  in  1  system clock, all logic on rising edge
reboot  in  1  synchronous active-high reset
is_enemy  in  1  IFF says hostile
target_locked  in  1  tracker lock
fire_command  in  1  operator trigger
firing_mode  in  2  00 single, 01 burst, 10 auto, 11 treated as single
overheat_sensor  in  1  barrel over-temperature
current_state  out  3  encoded FSM state
criticality_alert  out  1  high in OVERHEAT or DOWNFALL
fire_trigger  out  1  one-cycle pulse per round fired
rounds_left  out  CNT_W  rounds in current magazine
mags_left  out  MAG_W  spare magazines remaining

Behaviour:
- Clock and reset: one clock, sysclk; reboot is synchronous, active-high, and highest priority.
- Reset values: current_state=IDLE, rounds_left=MAG_SIZE, mags_left=MAG_COUNT, fire_trigger=0, criticality_alert=0, internal fire_command edge register=0, all timers=0.
- All outputs are registered.
- States: IDLE=0, ENGAGE=1, FIRING=2, RELOAD=3, OVERHEAT=4, DOWNFALL=5; codes 6/7 recover to IDLE on the next edge.
- valid = is_enemy & target_locked. rise = fire_command & ~fire_command_q.
- Priority each edge: reboot > overheat_sensor (any state except DOWNFALL → OVERHEAT, no shot that cycle) > rules below.
- IDLE: valid → ENGAGE.
- ENGAGE:
  - ~valid → IDLE.
  - mode single/burst: rise → FIRING.
  - mode auto: fire_command level → FIRING.
  - Burst counter loads BURST_LEN (single: 1) on entry.
- FIRING:
  - Each edge with valid: fire_trigger<=1, rounds_left decrements, burst counter decrements.
  - ~valid → IDLE, no shot.
  - single/burst: burst counter reaching 0 → ENGAGE.
  - auto: continues while fire_command high; fire_command low → ENGAGE with no shot.
- Magazine empty (shot leaves rounds_left=0):
  - Same edge → RELOAD if mags_left>0, else DOWNFALL.
  - Any remaining burst is discarded.
- Latency: FIRING entered at edge N; first fire_trigger at edge N+1. Auto fires one round per cycle.
- RELOAD:
  - Lasts exactly RELOAD_CYCLES cycles.
  - Exit edge: rounds_left<=MAG_SIZE, mags_left decrements, → ENGAGE if valid else IDLE.
- OVERHEAT:
  - Cooldown timer loads COOLDOWN_CYCLES on entry and reloads whenever overheat_sensor is high.
  - Timer decrements only while the sensor is low.
  - On reaching 0: → RELOAD if rounds_left==0 and mags_left>0, else IDLE.
  - An aborted reload restarts from the full count; rounds and magazines are unchanged by the abort.
- DOWNFALL: terminal, ignores all inputs including overheat; exited only by reboot.
- Arithmetic: counters never wrap. rounds_left and mags_left never decrement below 0.
- fire_trigger is 0 in every state except on FIRING shot edges.

Optional Feature:
Macro SMG_SHOT_COUNT_EN.
- Defined: adds output port total_shots [15:0]. It increments on every fire_trigger, saturates at 16'hFFFF, and is cleared by reboot.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reboot, valid=1, mode=10, fire_command held → 25 trigger pulses on consecutive edges, then rounds_left=0, RELOAD for 5 cycles, then rounds_left=25, mags_left=1, ENGAGE 1 cycle, firing resumes.
- Auto held continuously → exactly 75 pulses total, then current_state=5, criticality_alert=1; state holds through 100 further cycles with overheat toggling; reboot restores IDLE, 25 rounds, 2 spare magazines.
- Burst mode, three fire_command rising edges spaced 10 cycles apart → 9 pulses total, 3 per burst, rounds_left=16; holding fire_command high fires only 3.
- Single mode: 4 rising edges → 4 pulses, rounds_left=21. is_enemy dropped mid-burst → no further pulse, state IDLE next edge.
- Overheat asserted mid-auto for 3 cycles → pulses stop that edge, state 4, alert=1; returns to IDLE exactly 10 cycles after sensor falls. Re-asserting the sensor at cooldown cycle 7 restarts the 10-cycle count.
- Overheat during RELOAD → after cooldown, full 5-cycle reload occurs, mags_left decremented once. With SMG_SHOT_COUNT_EN defined, total_shots equals the pulse count in every scenario.
